// File: rtl/clock_set_ctrl_if.sv
// Request/status and CLOCK-facing signals of clock_set_ctrl.
// The slave modport is the sequencer; the master side is host logic plus CLOCK.
interface clock_set_ctrl_if;
  logic       start;
  logic       abort;
  logic [4:0] tgt_hr;
  logic [5:0] tgt_min;
  logic       tgt_pm;
  logic [4:0] cur_hr;
  logic [5:0] cur_min;
  logic       cur_pm;
  logic       set_hr;
  logic       set_min;
  logic       set_AMPM;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, abort, tgt_hr, tgt_min, tgt_pm, cur_hr, cur_min, cur_pm,
    input  set_hr, set_min, set_AMPM, busy, done, err
  );

  modport slave (
    input  start, abort, tgt_hr, tgt_min, tgt_pm, cur_hr, cur_min, cur_pm,
    output set_hr, set_min, set_AMPM, busy, done, err
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Steps CLOCK's hour, minute and AM/PM fields to a latched target with set pulses,
// settling and re-checking after each pulse, then verifying all fields together.
module clock_set_ctrl #(
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned MAX_RETRY = 3
) (
  input logic             clk,
  input logic             rst,
  clock_set_ctrl_if.slave bus
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [SW-1:0] SettleLast = SW'(SETTLE - 1);
  localparam logic [RW-1:0] RetryMax   = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    StIdle, StChkHr, StPulseHr, StWaitHr, StChkMin, StPulseMin, StWaitMin,
    StChkPm, StPulsePm, StWaitPm, StVerify, StDone, StErr
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      pcnt_q, pcnt_d;
  logic [SW-1:0]   wcnt_q, wcnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [4:0]      tgt_hr_q;
  logic [5:0]      tgt_min_q;
  logic            tgt_pm_q, tgt_ok_q;
  logic            latch;
  logic            set_hr_q, set_min_q, set_pm_q, busy_q, done_q, err_q;

  logic tgt_ok_in;
  assign tgt_ok_in = (bus.tgt_hr >= 5'd1) && (bus.tgt_hr <= 5'd12) && (bus.tgt_min <= 6'd59);

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    wcnt_d  = wcnt_q;
    retry_d = retry_q;
    latch   = 1'b0;
    unique case (state_q)
      // DONE/ERR already count as the return to idle, so a new start is taken there too
      StIdle, StDone, StErr: begin
        state_d = StIdle;
        if (bus.start) begin
          latch   = 1'b1;
          pcnt_d  = '0;
          retry_d = '0;
          state_d = StChkHr;
        end
      end
      StChkHr: begin
        if (!tgt_ok_q) begin
          state_d = StErr;
        end else if (bus.cur_hr == tgt_hr_q) begin
          pcnt_d  = '0;
          state_d = StChkMin;
        end else if (pcnt_q >= 6'd12) begin
          state_d = StErr;
        end else begin
          state_d = StPulseHr;
        end
      end
      StChkMin: begin
        if (bus.cur_min == tgt_min_q) begin
          pcnt_d  = '0;
          state_d = StChkPm;
        end else if (pcnt_q >= 6'd60) begin
          state_d = StErr;
        end else begin
          state_d = StPulseMin;
        end
      end
      StChkPm: begin
        if (bus.cur_pm == tgt_pm_q) begin
          pcnt_d  = '0;
          state_d = StVerify;
        end else if (pcnt_q >= 6'd1) begin
          state_d = StErr;
        end else begin
          state_d = StPulsePm;
        end
      end
      StPulseHr, StPulseMin, StPulsePm: begin
        pcnt_d  = pcnt_q + 6'd1;
        wcnt_d  = '0;
        state_d = (state_q == StPulseHr)  ? StWaitHr :
                  (state_q == StPulseMin) ? StWaitMin : StWaitPm;
      end
      StWaitHr, StWaitMin, StWaitPm: begin
        if (wcnt_q == SettleLast) begin
          state_d = (state_q == StWaitHr)  ? StChkHr :
                    (state_q == StWaitMin) ? StChkMin : StChkPm;
        end else begin
          wcnt_d = wcnt_q + SW'(1);
        end
      end
      StVerify: begin
        if ((bus.cur_hr == tgt_hr_q) && (bus.cur_min == tgt_min_q) &&
            (bus.cur_pm == tgt_pm_q)) begin
          state_d = StDone;
        end else if (retry_q < RetryMax) begin
          retry_d = retry_q + RW'(1);
          state_d = StChkHr;
        end else begin
          state_d = StErr;
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.abort) begin
      state_d = StIdle;
      latch   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pcnt_q    <= '0;
      wcnt_q    <= '0;
      retry_q   <= '0;
      tgt_hr_q  <= '0;
      tgt_min_q <= '0;
      tgt_pm_q  <= 1'b0;
      tgt_ok_q  <= 1'b0;
      set_hr_q  <= 1'b0;
      set_min_q <= 1'b0;
      set_pm_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      wcnt_q    <= wcnt_d;
      retry_q   <= retry_d;
      if (latch) begin
        tgt_hr_q  <= bus.tgt_hr;
        tgt_min_q <= bus.tgt_min;
        tgt_pm_q  <= bus.tgt_pm;
        tgt_ok_q  <= tgt_ok_in;
      end
      // Outputs are registered images of the next state
      set_hr_q  <= (state_d == StPulseHr);
      set_min_q <= (state_d == StPulseMin);
      set_pm_q  <= (state_d == StPulsePm);
      busy_q    <= !((state_d == StIdle) || (state_d == StDone) || (state_d == StErr));
      done_q    <= (state_d == StDone);
      err_q     <= (state_d == StErr);
    end
  end

  assign bus.set_hr   = set_hr_q;
  assign bus.set_min  = set_min_q;
  assign bus.set_AMPM = set_pm_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: two instances (MAX_RETRY 3 and 0), each with a
// behavioural CLOCK model, driven by directed and randomized set requests.
module tb_clock_set_ctrl;
  localparam int SET = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_set_ctrl_if bus0 ();
  clock_set_ctrl_if bus1 ();

  clock_set_ctrl #(.SETTLE(SET), .MAX_RETRY(3)) dut (.clk(clk), .rst(rst), .bus(bus0));
  clock_set_ctrl #(.SETTLE(SET), .MAX_RETRY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int failures = 0;

  // Host-side drives
  logic [1:0] st = '0, ab = '0;
  logic [4:0] th [2];
  logic [5:0] tm [2];
  logic [1:0] tp = '0;
  assign bus0.start = st[0];  assign bus1.start = st[1];
  assign bus0.abort = ab[0];  assign bus1.abort = ab[1];
  assign bus0.tgt_hr = th[0]; assign bus1.tgt_hr = th[1];
  assign bus0.tgt_min = tm[0]; assign bus1.tgt_min = tm[1];
  assign bus0.tgt_pm = tp[0]; assign bus1.tgt_pm = tp[1];

  logic [1:0] s_hr, s_min, s_pm, s_busy, s_done, s_err;
  assign s_hr   = {bus1.set_hr, bus0.set_hr};
  assign s_min  = {bus1.set_min, bus0.set_min};
  assign s_pm   = {bus1.set_AMPM, bus0.set_AMPM};
  assign s_busy = {bus1.busy, bus0.busy};
  assign s_done = {bus1.done, bus0.done};
  assign s_err  = {bus1.err, bus0.err};

  // CLOCK models
  logic [4:0] m_hr [2];
  logic [5:0] m_min [2];
  logic [1:0] m_pm, pre_go = '0, freeze = '0, inject = '0, inj_used;
  logic [4:0] pre_hr [2];
  logic [5:0] pre_min [2];
  logic [1:0] pre_pm;
  assign bus0.cur_hr = m_hr[0];   assign bus1.cur_hr = m_hr[1];
  assign bus0.cur_min = m_min[0]; assign bus1.cur_min = m_min[1];
  assign bus0.cur_pm = m_pm[0];   assign bus1.cur_pm = m_pm[1];

  function automatic logic [4:0] next_hr(input logic [4:0] h);
    return (h == 5'd12) ? 5'd1 : h + 5'd1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pre_go[k]) begin
        m_hr[k] <= pre_hr[k]; m_min[k] <= pre_min[k]; m_pm[k] <= pre_pm[k];
        inj_used[k] <= 1'b0;
      end else begin
        if (s_hr[k] && !freeze[k]) m_hr[k] <= next_hr(m_hr[k]);
        if (s_min[k]) begin
          m_min[k] <= (m_min[k] == 6'd59) ? 6'd0 : m_min[k] + 6'd1;
          // Spurious hour carry during the minute sequence
          if (inject[k] && !inj_used[k]) begin
            m_hr[k] <= next_hr(m_hr[k]);
            inj_used[k] <= 1'b1;
          end
        end
        if (s_pm[k]) m_pm[k] <= ~m_pm[k];
      end
    end
  end

  // Monitor: cumulative counts, sampled mid-cycle
  int n_hr [2], n_min [2], n_pm [2], n_busy [2], n_done [2], n_err [2];
  int viol = 0;
  int cyc = 0;
  int evt_kind [$];
  int evt_cyc [$];
  initial for (int k = 0; k < 2; k++) begin
    n_hr[k] = 0; n_min[k] = 0; n_pm[k] = 0; n_busy[k] = 0; n_done[k] = 0; n_err[k] = 0;
  end
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      n_hr[k]   = n_hr[k] + (s_hr[k] ? 1 : 0);
      n_min[k]  = n_min[k] + (s_min[k] ? 1 : 0);
      n_pm[k]   = n_pm[k] + (s_pm[k] ? 1 : 0);
      n_busy[k] = n_busy[k] + (s_busy[k] ? 1 : 0);
      n_done[k] = n_done[k] + (s_done[k] ? 1 : 0);
      n_err[k]  = n_err[k] + (s_err[k] ? 1 : 0);
      if ((s_hr[k] ? 1 : 0) + (s_min[k] ? 1 : 0) + (s_pm[k] ? 1 : 0) > 1) viol = viol + 1;
    end
    if (s_hr[0])  begin evt_kind.push_back(1); evt_cyc.push_back(cyc); end
    if (s_min[0]) begin evt_kind.push_back(2); evt_cyc.push_back(cyc); end
    if (s_pm[0])  begin evt_kind.push_back(3); evt_cyc.push_back(cyc); end
    cyc = cyc + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic preset(input int k, input logic [4:0] h, input logic [5:0] m, input logic p);
    pre_hr[k] = h; pre_min[k] = m; pre_pm[k] = p; pre_go[k] = 1'b1;
    tick();
    pre_go[k] = 1'b0;
  endtask

  // Issues start, returns cycle offset of done/err relative to the start edge (kind 1/2, 0 = none)
  task automatic run(input int k, input logic [4:0] h, input logic [5:0] m, input logic p,
                     input int budget, output int t_end, output int kind);
    tick();
    th[k] = h; tm[k] = m; tp[k] = p; st[k] = 1'b1;
    tick();
    st[k] = 1'b0;
    th[k] = 5'($urandom); tm[k] = 6'($urandom); tp[k] = 1'($urandom);
    t_end = 0; kind = 0;
    for (int i = 1; i <= budget; i++) begin
      if (s_done[k]) begin t_end = i; kind = 1; break; end
      if (s_err[k])  begin t_end = i; kind = 2; break; end
      tick();
    end
  endtask

  function automatic int hr_steps(input int c, input int t);
    return ((t - c) % 12 + 12) % 12;
  endfunction
  function automatic int min_steps(input int c, input int t);
    return ((t - c) % 60 + 60) % 60;
  endfunction
  // Completion offset: four compare cycles plus DONE, each pulse costs pulse+settle+compare
  function automatic int done_at(input int pulses, input int retries);
    return 5 + pulses * (SET + 2) + retries * 4;
  endfunction

  task automatic test_reset();
    preset(0, 5'd3, 6'd10, 1'b0);
    preset(1, 5'd3, 6'd10, 1'b0);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({s_hr[k], s_min[k], s_pm[k], s_busy[k], s_done[k], s_err[k]} !== 6'b0) begin
        failures++;
        $display("FAIL reset_outputs[%0d]: got %b want 000000", k,
                 {s_hr[k], s_min[k], s_pm[k], s_busy[k], s_done[k], s_err[k]});
      end
    end
  endtask

  task automatic test_basic();
    int t, kind, base, hr0, mn0, pm0, code, gap;
    preset(0, 5'd3, 6'd10, 1'b0);
    base = evt_kind.size(); hr0 = n_hr[0]; mn0 = n_min[0]; pm0 = n_pm[0];
    run(0, 5'd5, 6'd12, 1'b1, 200, t, kind);
    tick();
    checks++;
    if (kind !== 1 || t !== done_at(5, 0)) begin
      failures++; $display("FAIL basic_done: kind=%0d t=%0d want kind=1 t=%0d", kind, t, done_at(5, 0));
    end
    checks++;
    if ({n_hr[0] - hr0, n_min[0] - mn0, n_pm[0] - pm0} !== {32'd2, 32'd2, 32'd1}) begin
      failures++;
      $display("FAIL basic_counts: hr=%0d min=%0d pm=%0d want 2 2 1",
               n_hr[0] - hr0, n_min[0] - mn0, n_pm[0] - pm0);
    end
    code = 0; gap = 1000;
    for (int i = base; i < evt_kind.size(); i++) begin
      code = code * 4 + evt_kind[i];
      if (i > base && evt_cyc[i] - evt_cyc[i-1] < gap) gap = evt_cyc[i] - evt_cyc[i-1];
    end
    checks++;
    // Sequence H,H,M,M,P encoded base 4 with H=1, M=2, P=3
    if (code !== 363) begin
      failures++; $display("FAIL basic_order: code=%0d want 363", code);
    end
    checks++;
    if (gap < 3) begin
      failures++; $display("FAIL basic_spacing: min gap=%0d want >=3", gap);
    end
    checks++;
    if ({m_hr[0], m_min[0], m_pm[0]} !== {5'd5, 6'd12, 1'b1}) begin
      failures++; $display("FAIL basic_final: %0d:%0d pm=%0d want 5:12 pm=1", m_hr[0], m_min[0], m_pm[0]);
    end
  endtask

  task automatic test_equal();
    int t, kind, b0;
    preset(0, 5'd9, 6'd45, 1'b1);
    b0 = n_busy[0];
    run(0, 5'd9, 6'd45, 1'b1, 20, t, kind);
    checks++;
    if (kind !== 1 || t !== 5) begin
      failures++; $display("FAIL equal_done: kind=%0d t=%0d want kind=1 t=5", kind, t);
    end
    tick();
    checks++;
    if (n_busy[0] - b0 !== 4) begin
      failures++; $display("FAIL equal_busy: busy cycles=%0d want 4", n_busy[0] - b0);
    end
  endtask

  task automatic test_wrap();
    int t, kind, hr0, mn0, pm0;
    preset(0, 5'd11, 6'd58, 1'b0);
    hr0 = n_hr[0]; mn0 = n_min[0]; pm0 = n_pm[0];
    run(0, 5'd2, 6'd1, 1'b0, 200, t, kind);
    tick();
    checks++;
    if (kind !== 1 || {n_hr[0] - hr0, n_min[0] - mn0, n_pm[0] - pm0} !== {32'd3, 32'd3, 32'd0}) begin
      failures++;
      $display("FAIL wrap: kind=%0d hr=%0d min=%0d pm=%0d want done 3 3 0", kind,
               n_hr[0] - hr0, n_min[0] - mn0, n_pm[0] - pm0);
    end
  endtask

  task automatic test_invalid();
    logic [4:0] hs [3];
    logic [5:0] ms [3];
    int t, kind, p0, b0;
    hs[0] = 5'd4;  ms[0] = 6'd60;
    hs[1] = 5'd0;  ms[1] = 6'd30;
    hs[2] = 5'd13; ms[2] = 6'd30;
    preset(0, 5'd7, 6'd7, 1'b0);
    for (int c = 0; c < 3; c++) begin
      p0 = n_hr[0] + n_min[0] + n_pm[0]; b0 = n_busy[0];
      run(0, hs[c], ms[c], 1'b1, 10, t, kind);
      repeat (3) tick();
      checks++;
      if (kind !== 2 || t !== 2) begin
        failures++; $display("FAIL invalid_err[%0d]: kind=%0d t=%0d want kind=2 t=2", c, kind, t);
      end
      checks++;
      if (n_hr[0] + n_min[0] + n_pm[0] - p0 !== 0 || n_busy[0] - b0 !== 1) begin
        failures++;
        $display("FAIL invalid_quiet[%0d]: pulses=%0d busy=%0d want 0 1", c,
                 n_hr[0] + n_min[0] + n_pm[0] - p0, n_busy[0] - b0);
      end
    end
  endtask

  task automatic test_frozen();
    int t, kind, hr0, mn0, pm0;
    preset(0, 5'd3, 6'd20, 1'b0);
    freeze[0] = 1'b1;
    hr0 = n_hr[0]; mn0 = n_min[0]; pm0 = n_pm[0];
    run(0, 5'd5, 6'd20, 1'b0, 200, t, kind);
    tick();
    freeze[0] = 1'b0;
    checks++;
    if (kind !== 2 || t !== 1 + 12 * (SET + 2) + 1) begin
      failures++; $display("FAIL frozen_err: kind=%0d t=%0d want kind=2 t=%0d", kind, t, 2 + 12 * (SET + 2));
    end
    checks++;
    if ({n_hr[0] - hr0, n_min[0] - mn0, n_pm[0] - pm0} !== {32'd12, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL frozen_counts: hr=%0d min=%0d pm=%0d want 12 0 0",
               n_hr[0] - hr0, n_min[0] - mn0, n_pm[0] - pm0);
    end
  endtask

  task automatic test_retry();
    int t, kind, hr0, mn0;
    preset(0, 5'd4, 6'd20, 1'b0);
    inject[0] = 1'b1;
    hr0 = n_hr[0]; mn0 = n_min[0];
    run(0, 5'd6, 6'd25, 1'b0, 300, t, kind);
    tick();
    inject[0] = 1'b0;
    checks++;
    if (kind !== 1 || t !== done_at(2 + 5 + 11, 1)) begin
      failures++; $display("FAIL retry_done: kind=%0d t=%0d want kind=1 t=%0d", kind, t, done_at(18, 1));
    end
    checks++;
    if (n_hr[0] - hr0 !== 13 || n_min[0] - mn0 !== 5) begin
      failures++; $display("FAIL retry_counts: hr=%0d min=%0d want 13 5", n_hr[0] - hr0, n_min[0] - mn0);
    end
  endtask

  task automatic test_no_retry();
    int t, kind, hr0, mn0;
    preset(1, 5'd4, 6'd20, 1'b0);
    inject[1] = 1'b1;
    hr0 = n_hr[1]; mn0 = n_min[1];
    run(1, 5'd6, 6'd25, 1'b0, 300, t, kind);
    tick();
    inject[1] = 1'b0;
    checks++;
    if (kind !== 2 || t !== done_at(7, 0)) begin
      failures++; $display("FAIL noretry_err: kind=%0d t=%0d want kind=2 t=%0d", kind, t, done_at(7, 0));
    end
    checks++;
    if (n_hr[1] - hr0 !== 2 || n_min[1] - mn0 !== 5) begin
      failures++; $display("FAIL noretry_counts: hr=%0d min=%0d want 2 5", n_hr[1] - hr0, n_min[1] - mn0);
    end
  endtask

  task automatic test_random();
    int t, kind, ch, cm, cp, gh, gm, gp, eh, em, ep, hr0, mn0, pm0;
    for (int it = 0; it < 8; it++) begin
      ch = $urandom_range(1, 12); cm = $urandom_range(0, 59); cp = $urandom_range(0, 1);
      gh = $urandom_range(1, 12); gm = $urandom_range(0, 59); gp = $urandom_range(0, 1);
      eh = hr_steps(ch, gh); em = min_steps(cm, gm); ep = (gp != cp) ? 1 : 0;
      preset(0, 5'(ch), 6'(cm), 1'(cp));
      hr0 = n_hr[0]; mn0 = n_min[0]; pm0 = n_pm[0];
      run(0, 5'(gh), 6'(gm), 1'(gp), 400, t, kind);
      tick();
      checks++;
      if (kind !== 1 || t !== done_at(eh + em + ep, 0)) begin
        failures++;
        $display("FAIL rand_done[%0d]: kind=%0d t=%0d want kind=1 t=%0d", it, kind, t,
                 done_at(eh + em + ep, 0));
      end
      checks++;
      if (n_hr[0] - hr0 !== eh || n_min[0] - mn0 !== em || n_pm[0] - pm0 !== ep ||
          {m_hr[0], m_min[0], m_pm[0]} !== {5'(gh), 6'(gm), 1'(gp)}) begin
        failures++;
        $display("FAIL rand_counts[%0d]: hr=%0d min=%0d pm=%0d want %0d %0d %0d", it,
                 n_hr[0] - hr0, n_min[0] - mn0, n_pm[0] - pm0, eh, em, ep);
      end
    end
  endtask

  // Interrupts a sequence (reset when use_rst, else abort), then checks silence and a fresh run
  task automatic test_interrupt(input bit use_rst);
    int t, kind, d0, e0, eh, em, ep, hr0, mn0, pm0;
    bit seen;
    preset(0, 5'd3, 6'd10, 1'b0);
    tick();
    th[0] = 5'd7; tm[0] = 6'd15; tp[0] = 1'b0; st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (use_rst ? s_min[0] : s_hr[0]) begin seen = 1'b1; break; end
      tick();
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL interrupt_reach[%0d]: target pulse seen=0 want 1", use_rst);
    end
    if (use_rst) rst = 1'b1;
    else begin
      tick();
      ab[0] = 1'b1;
    end
    d0 = n_done[0]; e0 = n_err[0];
    tick();
    rst = 1'b0; ab[0] = 1'b0;
    checks++;
    if ({s_hr[0], s_min[0], s_pm[0], s_busy[0], s_done[0], s_err[0]} !== 6'b0) begin
      failures++;
      $display("FAIL interrupt_outputs[%0d]: got %b want 000000", use_rst,
               {s_hr[0], s_min[0], s_pm[0], s_busy[0], s_done[0], s_err[0]});
    end
    repeat (10) tick();
    checks++;
    if (n_done[0] - d0 !== 0 || n_err[0] - e0 !== 0) begin
      failures++;
      $display("FAIL interrupt_quiet[%0d]: done=%0d err=%0d want 0 0", use_rst,
               n_done[0] - d0, n_err[0] - e0);
    end
    eh = hr_steps(int'(m_hr[0]), 8); em = min_steps(int'(m_min[0]), 30); ep = (m_pm[0] != 1'b0) ? 1 : 0;
    hr0 = n_hr[0]; mn0 = n_min[0]; pm0 = n_pm[0];
    run(0, 5'd8, 6'd30, 1'b0, 400, t, kind);
    tick();
    checks++;
    if (kind !== 1 || t !== done_at(eh + em + ep, 0) || n_hr[0] - hr0 !== eh ||
        n_min[0] - mn0 !== em || n_pm[0] - pm0 !== ep) begin
      failures++;
      $display("FAIL interrupt_rerun[%0d]: kind=%0d t=%0d want kind=1 t=%0d", use_rst, kind, t,
               done_at(eh + em + ep, 0));
    end
  endtask

  initial begin
    th[0] = '0; th[1] = '0; tm[0] = '0; tm[1] = '0;
    test_reset();
    test_basic();
    test_equal();
    test_wrap();
    test_invalid();
    test_frozen();
    test_retry();
    test_no_retry();
    test_random();
    test_interrupt(1'b1);
    test_interrupt(1'b0);
    checks++;
    if (viol !== 0) begin
      failures++; $display("FAIL pulse_exclusive: overlapping cycles=%0d want 0", viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
